reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Shares one bank of NrOfRegs single-bit-vector holding registers between NrOfRequesters masters.
- Each register is a NrOfBits flop with ClockEnable/Tick load, asynchronous clear and preset, and a tri-state Q with active-high disable (cs).
- The arbiter serialises requests round-robin and drives each register's ClockEnable, cs, pre and clear controls.
- It returns read data from the shared Q bus and sits between the recognition datapath stages and the register bank.

Parameters:
- NrOfBits, 8, data width of each register and of the shared D/Q buses.
- NrOfRequesters, 4, number of masters; range 2..8.
- NrOfRegs, 8, number of registers in the bank; range 2..16.
- AddrBits, 3, register address width; must satisfy 2^AddrBits >= NrOfRegs.

Ports:
- Clock, in, 1, single system clock; all state on rising edge.
- Reset, in, 1, asynchronous active-low reset; 0 = reset.
- Tick, in, 1, global tick enable; register accesses commit only on a cycle with Tick=1.
- req, in, NrOfRequesters, per-master request; held until done.
- op, in, 2*NrOfRequesters, per-master opcode: 00 read, 01 write, 10 preset, 11 clear.
- addr, in, AddrBits*NrOfRequesters, per-master register address.
- wdata, in, NrOfBits*NrOfRequesters, per-master write data.
- gnt, out, NrOfRequesters, one-hot grant; high during ACCESS.
- done, out, NrOfRequesters, one-cycle completion pulse to the winning master.
- err, out, 1, pulses with done when the latched addr >= NrOfRegs.
- rdata, out, NrOfBits, last read result; held until the next read completes.
- reg_D, out, NrOfBits, shared data to all registers' D.
- reg_ClockEnable, out, NrOfRegs, per-register load enable.
- reg_cs, out, NrOfRegs, per-register output disable; 1 = high-Z.
- reg_pre, out, NrOfRegs, per-register asynchronous preset.
- reg_clr, out, NrOfRegs, per-register asynchronous clear.
- reg_Q, in, NrOfBits, shared tri-state bus from the register outputs.

Behaviour:
- All outputs come straight from flops; there is no combinational path to reg_pre/reg_clr, so these async controls are glitch-free.
- Reset (asynchronous, Reset=0), any time, including mid-ACCESS:
  - state IDLE; rr_ptr=0.
  - gnt, done, err = 0; rdata = 0; reg_D = 0.
  - reg_ClockEnable, reg_pre, reg_clr = 0; reg_cs = all ones.
  - An aborted access leaves the target register content undefined from the arbiter's view.
- State IDLE:
  - If any req bit is set, pick the winner as the first set bit at or after rr_ptr, wrapping.
  - Latch the winner's op, addr and wdata; set gnt[winner]; set rr_ptr = winner+1 mod NrOfRequesters; go to ACCESS.
  - The target controls are asserted on the same edge, only if addr < NrOfRegs:
    - write: reg_D = wdata, reg_ClockEnable[addr] = 1.
    - read: reg_cs[addr] = 0.
    - preset: reg_pre[addr] = 1.
    - clear: reg_clr[addr] = 1.
- State ACCESS:
  - Hold all controls while Tick=0.
  - On a cycle with Tick=1:
    - read: rdata <= reg_Q.
    - Deassert all reg_* controls (reg_cs back to all ones) and gnt.
    - Pulse done[winner] = 1; err = 1 if addr is out of range; go to RESP.
  - A write commits on that same edge, because the register samples ClockEnable&Tick.
- State RESP: done and err clear; return to IDLE. No new grant is issued in this cycle.
- Latency: req seen at edge N, gnt high after N+1; if Tick=1 during ACCESS, done is high after N+2; IDLE after N+3. Earliest back-to-back grant is 3 cycles apart.
- req dropped during ACCESS: the latched transaction still completes and done is still pulsed.
- Requests arriving during ACCESS/RESP wait; at most one reg_cs bit is ever 0, so there is no bus contention.
- Out-of-range addr: no register touched, rdata unchanged, err pulses with done.

Optional Feature:
- Macro REGARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest-index requesting master always wins and rr_ptr is not implemented.
- Undefined (default): round-robin exactly as described in Behaviour.

Test Plan:
- Reset=0 mid-ACCESS of a write to reg 2 -> outputs immediately go to reset values: reg_cs = 0xFF, gnt = 0, reg_ClockEnable = 0; after release, state IDLE and rr_ptr = 0.
- Master 1 writes 0xA5 to reg 3 with Tick tied 1, then reads reg 3 -> write done pulses 2 cycles after the req edge; the read returns rdata = 0xA5 and done[1] pulses.
- Masters 0, 2 and 3 hold req continuously -> grant order 0, 2, 3, 0, 2, 3; under REGARB_FIXED_PRIORITY_EN, master 0 wins every time.
- Master 0 issues preset on reg 5, then clear on reg 5 -> reg_pre[5], then reg_clr[5], each high for exactly the ACCESS cycles; a subsequent read returns 0x00.
- Tick low for 4 cycles during an ACCESS read -> gnt and reg_cs[addr]=0 held for 4 extra cycles; done pulses only after the Tick=1 cycle.
- Write to addr 9 with NrOfRegs=8, AddrBits=4 -> no reg_* control asserted; done and err both pulse for one cycle; rdata unchanged.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter serialising master accesses onto a shared register bank.
// Define REGARB_FIXED_PRIORITY_EN to make the lowest-index requester always win (no rr_ptr).
module reg_bank_arbiter #(
  parameter int unsigned NrOfBits       = 8,
  parameter int unsigned NrOfRequesters = 4,
  parameter int unsigned NrOfRegs       = 8,
  parameter int unsigned AddrBits       = 3
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic                                Tick,
  input  logic [NrOfRequesters-1:0]           req,
  input  logic [2*NrOfRequesters-1:0]         op,
  input  logic [AddrBits*NrOfRequesters-1:0]  addr,
  input  logic [NrOfBits*NrOfRequesters-1:0]  wdata,
  output logic [NrOfRequesters-1:0]           gnt,
  output logic [NrOfRequesters-1:0]           done,
  output logic                                err,
  output logic [NrOfBits-1:0]                 rdata,
  output logic [NrOfBits-1:0]                 reg_D,
  output logic [NrOfRegs-1:0]                 reg_ClockEnable,
  output logic [NrOfRegs-1:0]                 reg_cs,
  output logic [NrOfRegs-1:0]                 reg_pre,
  output logic [NrOfRegs-1:0]                 reg_clr,
  input  logic [NrOfBits-1:0]                 reg_Q
);

  localparam int unsigned IdxW = (NrOfRequesters > 1) ? $clog2(NrOfRequesters) : 1;
  localparam logic [1:0]  OpRead  = 2'b00;
  localparam logic [1:0]  OpWrite = 2'b01;
  localparam logic [1:0]  OpPre   = 2'b10;
  localparam logic [1:0]  OpClr   = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic [1:0]            op_q, op_d;
  logic                  oob_q, oob_d;
  logic [NrOfRequesters-1:0] gnt_q, gnt_d, done_q, done_d;
  logic                  err_q, err_d;
  logic [NrOfBits-1:0]   rdata_q, rdata_d, d_q, d_d;
  logic [NrOfRegs-1:0]   ce_q, ce_d, cs_q, cs_d, pre_q, pre_d, clr_q, clr_d;
`ifndef REGARB_FIXED_PRIORITY_EN
  logic [IdxW-1:0]       rr_q, rr_d;
`endif

  logic                  any_req;
  logic                  found;
  logic [IdxW-1:0]       win_c;
  logic [IdxW-1:0]       idx_v;
  logic [1:0]            op_sel;
  logic [AddrBits-1:0]   addr_sel;
  logic [NrOfBits-1:0]   wdata_sel;
  logic [NrOfRegs-1:0]   sel_dec;

  // Winner selection and decode of the winner's request fields
  always_comb begin
    any_req   = |req;
    found     = 1'b0;
    win_c     = '0;
    idx_v     = '0;
    op_sel    = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    sel_dec   = '0;
    for (int unsigned i = 0; i < NrOfRequesters; i++) begin
`ifdef REGARB_FIXED_PRIORITY_EN
      idx_v = IdxW'(i);
`else
      idx_v = IdxW'((32'(rr_q) + i) % NrOfRequesters);
`endif
      if (!found && req[idx_v]) begin
        found = 1'b1;
        win_c = idx_v;
      end
    end
    for (int unsigned i = 0; i < NrOfRequesters; i++) begin
      if (win_c == IdxW'(i)) begin
        op_sel    = op[2*i +: 2];
        addr_sel  = addr[AddrBits*i +: AddrBits];
        wdata_sel = wdata[NrOfBits*i +: NrOfBits];
      end
    end
    // Empty decode marks an out-of-range address
    for (int unsigned r = 0; r < NrOfRegs; r++) begin
      sel_dec[r] = (addr_sel == AddrBits'(r));
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_d    = op_q;
    oob_d   = oob_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    d_d     = d_q;
    ce_d    = ce_q;
    cs_d    = cs_q;
    pre_d   = pre_q;
    clr_d   = clr_q;
`ifndef REGARB_FIXED_PRIORITY_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          win_d   = win_c;
          op_d    = op_sel;
          oob_d   = ~|sel_dec;
          for (int unsigned i = 0; i < NrOfRequesters; i++) begin
            gnt_d[i] = (win_c == IdxW'(i));
          end
`ifndef REGARB_FIXED_PRIORITY_EN
          rr_d = (32'(win_c) == NrOfRequesters - 1) ? '0 : win_c + IdxW'(1);
`endif
          unique case (op_sel)
            OpWrite: begin
              if (|sel_dec) d_d = wdata_sel;
              ce_d = sel_dec;
            end
            OpRead:  cs_d  = ~sel_dec;
            OpPre:   pre_d = sel_dec;
            OpClr:   clr_d = sel_dec;
            default: ;
          endcase
        end
      end
      ACCESS: begin
        // Controls hold until a Tick cycle commits the access
        if (Tick) begin
          if (op_q == OpRead && !oob_q) rdata_d = reg_Q;
          ce_d    = '0;
          cs_d    = '1;
          pre_d   = '0;
          clr_d   = '0;
          gnt_d   = '0;
          for (int unsigned i = 0; i < NrOfRequesters; i++) begin
            done_d[i] = (win_q == IdxW'(i));
          end
          err_d   = oob_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      op_q    <= '0;
      oob_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      d_q     <= '0;
      ce_q    <= '0;
      cs_q    <= '1;
      pre_q   <= '0;
      clr_q   <= '0;
`ifndef REGARB_FIXED_PRIORITY_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op_q    <= op_d;
      oob_q   <= oob_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      d_q     <= d_d;
      ce_q    <= ce_d;
      cs_q    <= cs_d;
      pre_q   <= pre_d;
      clr_q   <= clr_d;
`ifndef REGARB_FIXED_PRIORITY_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign reg_D           = d_q;
  assign reg_ClockEnable = ce_q;
  assign reg_cs          = cs_q;
  assign reg_pre         = pre_q;
  assign reg_clr         = clr_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural 8-entry register bank on the Q bus.
module tb_reg_bank_arbiter;

  localparam int unsigned NB = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned NG = 8;
  localparam int unsigned AW = 4;

  logic            Clock, Reset, Tick;
  logic [NR-1:0]   req;
  logic [2*NR-1:0] op;
  logic [AW*NR-1:0] addr;
  logic [NB*NR-1:0] wdata;
  logic [NR-1:0]   gnt, done;
  logic            err;
  logic [NB-1:0]   rdata, reg_D, reg_Q;
  logic [NG-1:0]   reg_ClockEnable, reg_cs, reg_pre, reg_clr;

  reg_bank_arbiter #(.NrOfBits(NB), .NrOfRequesters(NR), .NrOfRegs(NG), .AddrBits(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .reg_D(reg_D),
    .reg_ClockEnable(reg_ClockEnable), .reg_cs(reg_cs), .reg_pre(reg_pre), .reg_clr(reg_clr),
    .reg_Q(reg_Q)
  );

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, PR = 2'b10, CL = 2'b11;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit cs_multi = 1'b0;
  logic [NB-1:0] bank [NG];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

  // Register bank model: preset/clear are held for the whole access, so edge sampling suffices
  always @(posedge Clock) begin
    for (int r = 0; r < int'(NG); r++) begin
      if (reg_clr[r]) bank[r] <= '0;
      else if (reg_pre[r]) bank[r] <= '1;
      else if (reg_ClockEnable[r] && Tick) bank[r] <= reg_D;
    end
  end

  always_comb begin
    reg_Q = '0;
    for (int r = 0; r < int'(NG); r++) if (!reg_cs[r]) reg_Q = bank[r];
  end

  always @(negedge Clock) if ($countones(~reg_cs) > 1) cs_multi = 1'b1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_master(input int m, input logic [1:0] o, input logic [3:0] a,
                              input logic [7:0] wd);
    op    = (op & ~(8'(2'b11) << (2*m))) | (8'(o) << (2*m));
    addr  = (addr & ~(16'(4'hF) << (4*m))) | (16'(a) << (4*m));
    wdata = (wdata & ~(32'(8'hFF) << (8*m))) | (32'(wd) << (8*m));
    req   = req | 4'(32'd1 << m);
  endtask

  task automatic wait_gnt(input string tag, output int idx);
    int n;
    n = 0;
    idx = -1;
    while (gnt == '0 && n < 20) begin
      @(posedge Clock); @(negedge Clock); n++;
    end
    if (gnt == '0) chk({tag, "_gnt_timeout"}, 32'(gnt), 32'hFFFF);
    for (int i = 0; i < int'(NR); i++) if (gnt == 4'(32'd1 << i)) idx = i;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done == '0 && n < 20) begin
      @(posedge Clock); @(negedge Clock); n++;
    end
    if (done == '0) chk({tag, "_done_timeout"}, 32'(done), 32'hFFFF);
  endtask

  // One full transaction from a single master, entered and left at a negedge
  task automatic run_txn(input string tag, input int m, input logic [1:0] o, input logic [3:0] a,
                         input logic [7:0] wd, input int hold, input logic [7:0] exp_rd,
                         input logic exp_err);
    int cyc;
    logic [7:0] dec, ce_e, cs_e, pre_e, clr_e;
    dec   = (a < 4'd8) ? 8'(32'd1 << a) : 8'h00;
    ce_e  = (o == WR) ? dec : 8'h00;
    cs_e  = (o == RD) ? ~dec : 8'hFF;
    pre_e = (o == PR) ? dec : 8'h00;
    clr_e = (o == CL) ? dec : 8'h00;
    drive_master(m, o, a, wd);
    Tick = (hold == 0);
    cyc = 0;
    while (gnt == '0 && cyc < 20) begin
      @(posedge Clock); @(negedge Clock); cyc++;
    end
    chk({tag, "_gnt"}, 32'(gnt), 32'(32'd1 << m));
    chk({tag, "_ctl"}, {ce_q_of(), reg_cs, reg_pre, reg_clr}, {ce_e, cs_e, pre_e, clr_e});
    if (o == WR && a < 4'd8) chk({tag, "_regD"}, 32'(reg_D), 32'(wd));
    for (int h = 0; h < hold; h++) begin
      @(posedge Clock); @(negedge Clock); cyc++;
      chk({tag, "_hold"}, {24'(gnt), reg_cs}, {24'(32'd1 << m), cs_e});
      chk({tag, "_hold_done"}, 32'(done), 32'h0);
    end
    Tick = 1'b1;
    while (done == '0 && cyc < 40) begin
      @(posedge Clock); @(negedge Clock); cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(2 + hold));
    chk({tag, "_done"}, 32'(done), 32'(32'd1 << m));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, "_released"}, {reg_ClockEnable, reg_cs, reg_pre, reg_clr}, 32'h00FF0000);
    req = req & ~4'(32'd1 << m);
    @(posedge Clock); @(negedge Clock);
    chk({tag, "_resp"}, {29'(gnt), done[0], err, 1'b0}, 32'h0);
    chk({tag, "_pulse"}, 32'(done), 32'h0);
  endtask

  function automatic logic [7:0] ce_q_of();
    return reg_ClockEnable;
  endfunction

  typedef struct {
    int         m;
    logic [1:0] o;
    logic [3:0] a;
    logic [7:0] wd;
    int         hold;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vt[11];
  int   rr_exp[6];
  int   idx, last;

  initial begin
    vt[0]  = '{1, WR, 4'd3, 8'hA5, 0, 8'h00, 1'b0};
    vt[1]  = '{1, RD, 4'd3, 8'h00, 0, 8'hA5, 1'b0};
    vt[2]  = '{0, PR, 4'd5, 8'h00, 0, 8'hA5, 1'b0};
    vt[3]  = '{0, RD, 4'd5, 8'h00, 0, 8'hFF, 1'b0};
    vt[4]  = '{0, CL, 4'd5, 8'h00, 0, 8'hFF, 1'b0};
    vt[5]  = '{0, RD, 4'd5, 8'h00, 0, 8'h00, 1'b0};
    vt[6]  = '{2, WR, 4'd0, 8'h3C, 0, 8'h00, 1'b0};
    vt[7]  = '{2, RD, 4'd0, 8'h00, 4, 8'h3C, 1'b0};
    vt[8]  = '{2, WR, 4'd9, 8'h5A, 0, 8'h3C, 1'b1};
    vt[9]  = '{3, RD, 4'd9, 8'h00, 0, 8'h3C, 1'b1};
    vt[10] = '{3, RD, 4'd3, 8'h00, 0, 8'hA5, 1'b0};
`ifdef REGARB_FIXED_PRIORITY_EN
    rr_exp = '{0, 0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 2, 3, 0, 2, 3};
`endif

    Reset = 1'b0; Tick = 1'b1; req = '0; op = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge Clock);
    chk("reset_gnt_done_err", {gnt, done, 7'h0, err}, 16'h0);
    chk("reset_data", {rdata, reg_D}, 16'h0);
    chk("reset_ctl", {reg_ClockEnable, reg_cs, reg_pre, reg_clr}, 32'h00FF0000);
    Reset = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("v%0d", i), vt[i].m, vt[i].o, vt[i].a, vt[i].wd, vt[i].hold,
              vt[i].exp_rd, vt[i].exp_err);

    // Asynchronous reset in the middle of a held write to reg 2
    drive_master(1, WR, 4'd2, 8'h11);
    Tick = 1'b0;
    wait_gnt("arst", idx);
    chk("arst_pre_ce", 32'(reg_ClockEnable), 32'h04);
    #2 Reset = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_ctl", {reg_ClockEnable, reg_cs, reg_pre, reg_clr}, 32'h00FF0000);
    chk("arst_data", {rdata, reg_D}, 16'h0);
    req = '0; Tick = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("arst_idle", {gnt, done}, 8'h0);

    // rr_ptr back at 0: master 1 beats master 3
    drive_master(1, RD, 4'd3, 8'h00);
    drive_master(3, RD, 4'd3, 8'h00);
    wait_gnt("rst_rr1", idx);
    chk("rst_rr_first", 32'(idx), 32'd1);
    wait_done("rst_rr1");
    req = req & ~4'b0010;
    wait_gnt("rst_rr2", idx);
    chk("rst_rr_second", 32'(idx), 32'd3);
    wait_done("rst_rr2");
    chk("rst_rr_rdata", 32'(rdata), 32'hA5);
    req = '0;
    repeat (2) @(negedge Clock);

    // Continuous requests from masters 0, 2 and 3
    drive_master(0, RD, 4'd3, 8'h00);
    drive_master(2, RD, 4'd3, 8'h00);
    drive_master(3, RD, 4'd3, 8'h00);
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_gnt($sformatf("rr%0d", k), idx);
      chk($sformatf("rr_order%0d", k), 32'(idx), 32'(rr_exp[k]));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(cyc_cnt - last), 32'd3);
      last = cyc_cnt;
      wait_done($sformatf("rr%0d", k));
      if (k == 5) req = '0;
    end
    repeat (2) @(negedge Clock);

    // Request withdrawn during ACCESS still completes
    drive_master(2, WR, 4'd1, 8'h77);
    wait_gnt("drop", idx);
    req = '0;
    wait_done("drop");
    chk("drop_done", 32'(done), 32'h4);
    repeat (2) @(negedge Clock);
    run_txn("drop_rd", 2, RD, 4'd1, 8'h00, 0, 8'h77, 1'b0);

    chk("cs_at_most_one_low", 32'(cs_multi), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
